// File: rtl/rmii_frame_checker.sv
// RMII receive-side frame checker: preamble/SFD detection, dibit-to-byte assembly, header, length and CRC-32 checks.
// Optional build macro MAC_FILTER_EN enables the destination MAC filter; without it the checker is promiscuous.
module rmii_frame_checker #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned MAX_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rxd,
    input  logic        crs_dv,
    output logic [31:0] data,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BYTES + 1);
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [2:0]  PRE_MIN     = 3'd4;
`ifdef MAC_FILTER_EN
    localparam bit MAC_FILTER_ON = 1'b1;
`else
    localparam bit MAC_FILTER_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DROP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [5:0]       sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [31:0]      hold_q, hold_d;
    logic             mac_loc_q, mac_loc_d;
    logic             mac_bc_q, mac_bc_d;
    logic [31:0]      data_d;
    logic             valid_d, err_d, busy_d;
    logic             take;
    logic [7:0]       byte_c;
    logic             loc_ok, bc_ok;

    // Reflected CRC-32 advanced by one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return LOCAL_MAC[47:40];
            3'd1:    return LOCAL_MAC[39:32];
            3'd2:    return LOCAL_MAC[31:24];
            3'd3:    return LOCAL_MAC[23:16];
            3'd4:    return LOCAL_MAC[15:8];
            default: return LOCAL_MAC[7:0];
        endcase
    endfunction

    // crs_dv low at a non-zero phase is the RMII toggle; the dibit is still data
    assign take   = crs_dv | (phase_q != 2'd0);
    assign byte_c = {rxd, sh_q};
    assign loc_ok = mac_loc_q && (byte_c == mac_byte(cnt_q[2:0]));
    assign bc_ok  = mac_bc_q && (byte_c == 8'hFF);

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        phase_d   = phase_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        hold_d    = hold_q;
        mac_loc_d = mac_loc_q;
        mac_bc_d  = mac_bc_q;
        data_d    = data;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy;
        case (state_q)
            IDLE: begin
                if (crs_dv) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = (rxd == 2'b01) ? 3'd1 : 3'd0;
                end
            end
            PREAMBLE: begin
                if (!crs_dv) begin
                    state_d = IDLE;
                end else if (rxd == 2'b01) begin
                    if (pre_cnt_q != PRE_MIN) pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (rxd == 2'b11 && pre_cnt_q == PRE_MIN) begin
                    state_d   = FRAME;
                    busy_d    = 1'b1;
                    phase_d   = 2'd0;
                    cnt_d     = '0;
                    crc_d     = CRC_INIT;
                    mac_loc_d = 1'b1;
                    mac_bc_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FRAME: begin
                if (!take) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (cnt_q < CNT_MIN || crc_q != CRC_RESIDUE) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = hold_q;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                    sh_d    = {rxd, sh_q[5:2]};
                    if (phase_q == 2'd3) begin
                        crc_d = crc_byte(crc_q, byte_c);
                        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                        if (cnt_q < CNT_W'(6)) begin
                            mac_loc_d = loc_ok;
                            mac_bc_d  = bc_ok;
                            if (MAC_FILTER_ON && !loc_ok && !bc_ok) state_d = DROP;
                        end
                        if (cnt_q == CNT_W'(12) && byte_c != ETHERTYPE[15:8]) state_d = DROP;
                        if (cnt_q == CNT_W'(13) && byte_c != ETHERTYPE[7:0])  state_d = DROP;
                        if (cnt_q >= CNT_W'(14) && cnt_q <= CNT_W'(17)) hold_d = {hold_q[23:0], byte_c};
                        if (cnt_q == CNT_MAX) begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (!take) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            phase_q   <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            hold_q    <= '0;
            mac_loc_q <= 1'b0;
            mac_bc_q  <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            phase_q   <= phase_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            hold_q    <= hold_d;
            mac_loc_q <= mac_loc_d;
            mac_bc_q  <= mac_bc_d;
            data      <= data_d;
            valid     <= valid_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rmii_frame_checker.sv
// Bench for rmii_frame_checker: frame-level model builds expected output timelines, compared every cycle.
module tb_rmii_frame_checker;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] ETYPE     = 16'h88B5;
    localparam int MINB = 64;
    localparam int MAXB = 1522;
    localparam int NONE = 100000;
`ifdef MAC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic        crs_dv = 1'b0;
    logic [31:0] data;
    logic        valid, err, busy;

    always #10 clk = ~clk;

    rmii_frame_checker dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .crs_dv(crs_dv),
        .data(data), .valid(valid), .err(err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int n_valid_seen = 0;
    int n_err_seen = 0;
    bit chk_en = 1'b0;

    // expected outputs after the DUT samples the current inputs, and the resulting current expectation
    logic        nx_valid = 1'b0, nx_err = 1'b0, nx_busy = 1'b0;
    logic [31:0] nx_data = 32'h0;
    logic        ex_valid = 1'b0, ex_err = 1'b0, ex_busy = 1'b0;
    logic [31:0] ex_data = 32'h0;

    logic [7:0] fr [0:1599];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ex_valid <= nx_valid;
        ex_err   <= nx_err;
        ex_busy  <= nx_busy;
        ex_data  <= nx_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'b0, valid}, {31'b0, ex_valid});
            chk("err",   {31'b0, err},   {31'b0, ex_err});
            chk("busy",  {31'b0, busy},  {31'b0, ex_busy});
            chk("data",  data, ex_data);
            if (valid) n_valid_seen++;
            if (err)   n_err_seen++;
        end
    end

    // Ethernet FCS (final-inverted CRC-32) of fr[0..n-1], bit-serial
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fr[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [31:0] pl,
                         input int n, input bit bad_fcs, input bit zero_fcs);
        logic [31:0] f;
        for (int i = 0; i < n; i++) fr[i] = 8'h00;
        for (int k = 0; k < 6; k++) fr[k] = dst[47-8*k -: 8];
        fr[6]  = 8'h02;
        fr[11] = 8'h02;
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        fr[14] = pl[31:24];
        fr[15] = pl[23:16];
        fr[16] = pl[15:8];
        fr[17] = pl[7:0];
        f = zero_fcs ? 32'h0 : fcs_of(n - 4);
        fr[n-4] = f[7:0];
        fr[n-3] = f[15:8];
        fr[n-2] = f[23:16];
        fr[n-1] = f[31:24];
        if (bad_fcs) fr[n-2] = fr[n-2] ^ 8'h10;
    endtask

    task automatic drive(input logic [1:0] d, input logic dv, input logic rn);
        @(posedge clk);
        #1;
        rxd      = d;
        crs_dv   = dv;
        rst_n    = rn;
        nx_valid = 1'b0;
        nx_err   = 1'b0;
        if (!rn) begin
            nx_busy = 1'b0;
            nx_data = 32'h0;
        end
    endtask

    task automatic idle(input int cycles);
        for (int g = 0; g < cycles; g++) drive(2'b00, 1'b0, 1'b1);
    endtask

    // Sends fr[0..n-1] after a standard preamble; the frame outcome is derived from its content
    task automatic send_frame(input int n, input int tog_byte, input int rst_byte, input int gap);
        int          bad_at;
        bit          pl, pb, crc_ok, dropped, aborted, rn;
        logic [7:0]  cur, mb;
        logic [1:0]  d;
        bad_at = NONE;
        pl = 1'b1;
        pb = 1'b1;
        if (FILTER) begin
            for (int k = 0; k < 6; k++) begin
                mb = LOCAL_MAC[47-8*k -: 8];
                pl = pl && (fr[k] == mb);
                pb = pb && (fr[k] == 8'hFF);
                if (!pl && !pb && bad_at == NONE) bad_at = k;
            end
        end
        if (bad_at == NONE && fr[12] != ETYPE[15:8]) bad_at = 12;
        else if (bad_at == NONE && fr[13] != ETYPE[7:0]) bad_at = 13;
        crc_ok  = (fcs_of(n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]});
        dropped = 1'b0;
        aborted = 1'b0;
        for (int p = 0; p < 31; p++) drive(2'b01, 1'b1, 1'b1);
        drive(2'b11, 1'b1, 1'b1);
        nx_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int ph = 0; ph < 4; ph++) begin
                cur = fr[i];
                d   = cur[2*ph +: 2];
                rn  = !(i == rst_byte && ph < 3);
                drive(d, !(i == tog_byte && ph == 2), rn);
                if (!rn) aborted = 1'b1;
                if (ph == 3 && !aborted && !dropped) begin
                    if (i == bad_at) begin
                        dropped = 1'b1;
                    end else if (i + 1 == MAXB + 1) begin
                        nx_err  = 1'b1;
                        dropped = 1'b1;
                    end
                end
            end
        end
        drive(2'b00, 1'b0, 1'b1);
        if (!aborted) begin
            nx_busy = 1'b0;
            if (!dropped) begin
                if (n >= MINB && crc_ok) begin
                    nx_valid = 1'b1;
                    nx_data  = {fr[14], fr[15], fr[16], fr[17]};
                end else begin
                    nx_err = 1'b1;
                end
            end
        end
        idle(gap);
    endtask

    initial begin
        drive(2'b00, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(2'b00, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b0);
        idle(4);

        // pin the model's CRC against the well-known check value
        for (int i = 0; i < 9; i++) fr[i] = 8'(8'h31 + i);
        chk("crc_check_value", fcs_of(9), 32'hCBF4_3926);

        // good frame to local MAC
        build(LOCAL_MAC, ETYPE, 32'h1234_5678, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 20);
        chk("t1_data", data, 32'h1234_5678);
        chk("t1_valid_count", n_valid_seen, 1);

        // flipped FCS bit
        build(LOCAL_MAC, ETYPE, 32'h5566_7788, 64, 1'b1, 1'b0);
        send_frame(64, -1, -1, 20);
        chk("t2_data_kept", data, 32'h1234_5678);
        chk("t2_err_count", n_err_seen, 1);

        // wrong EtherType dropped silently, then good frame after 12-byte gap
        build(LOCAL_MAC, 16'h0800, 32'h1111_1111, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 48);
        build(LOCAL_MAC, ETYPE, 32'hAABB_CCDD, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 20);
        chk("t3_data", data, 32'hAABB_CCDD);
        chk("t3_valid_count", n_valid_seen, 2);
        chk("t3_err_count", n_err_seen, 1);

        // runt and overlength
        build(LOCAL_MAC, ETYPE, 32'h0102_0304, 40, 1'b0, 1'b0);
        send_frame(40, -1, -1, 20);
        chk("t4_err_count", n_err_seen, 2);
        build(BCAST, ETYPE, 32'h0506_0708, 1600, 1'b0, 1'b0);
        send_frame(1600, -1, -1, 20);
        chk("t5_err_count", n_err_seen, 3);
        chk("t5_busy_low", {31'b0, busy}, 32'h0);

        // crs_dv toggle inside the payload
        build(LOCAL_MAC, ETYPE, 32'hCAFE_F00D, 64, 1'b0, 1'b0);
        send_frame(64, 15, -1, 20);
        chk("t6_data", data, 32'hCAFE_F00D);

        // back-to-back frames with a single idle dibit between them
        build(BCAST, ETYPE, 32'h0102_0304, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 0);
        build(LOCAL_MAC, ETYPE, 32'hDEAD_BEEF, 70, 1'b0, 1'b0);
        send_frame(70, -1, -1, 20);
        chk("t7_data", data, 32'hDEAD_BEEF);
        chk("t7_valid_count", n_valid_seen, 5);

        // foreign destination MAC
        build(48'h02_00_00_00_00_09, ETYPE, 32'h0BAD_F00D, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 20);
        chk("t8_data", data, FILTER ? 32'hDEAD_BEEF : 32'h0BAD_F00D);

        // reset mid-frame, then a good broadcast frame
        build(BCAST, ETYPE, 32'h0102_0304, 64, 1'b0, 1'b1);
        send_frame(64, -1, 10, 20);
        chk("t9_data_reset", data, 32'h0);
        build(BCAST, ETYPE, 32'h5A5A_A5A5, 64, 1'b0, 1'b0);
        send_frame(64, -1, -1, 20);
        chk("t9_data", data, 32'h5A5A_A5A5);
        chk("final_valid_count", n_valid_seen, FILTER ? 6 : 7);
        chk("final_err_count", n_err_seen, 3);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
